// File: rtl/idli_fetch_m.sv
`default_nettype none
// ============================================================================
// Module   : idli_fetch_m
// Purpose  : Instruction fetch from a quad-SPI serial memory, presenting each
//            16-bit word to EX as four nibbles framed by a free-running counter.
// Revision : 1.0 - initial release
// ============================================================================
module idli_fetch_m #(
    parameter logic [15:0] RST_PC = 16'h0000
) (
    input  logic        i_fe_gck,
    input  logic        i_ex_rst_n,
    output logic [1:0]  o_fe_ctr,
    output logic [3:0]  o_fe_enc,
    output logic        o_fe_enc_vld,
    output logic [15:0] o_fe_pc,
    input  logic        i_fe_stall,
    input  logic        i_fe_redir,
    input  logic [15:0] i_fe_redir_pc,
    output logic        o_fe_mem_cs_n,
    output logic [3:0]  o_fe_mem_sio,
    output logic        o_fe_mem_oe,
    input  logic [3:0]  i_fe_mem_sio
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CMD   = 3'd1;
    localparam logic [2:0] c_ADDR  = 3'd2;
    localparam logic [2:0] c_DUMMY = 3'd3;
    localparam logic [2:0] c_DATA  = 3'd4;

    logic [1:0]  r_ctr;
    logic [2:0]  r_state;
    logic [15:0] r_addr;
    logic [15:0] r_pend_pc;
    logic        r_pend;
    logic [15:0] r_pc;
    logic        r_vld;
    logic [3:0]  r_enc;

    logic        w_slot_end;
    logic        w_pend;
    logic [15:0] w_pend_pc;
    logic        w_abort;
    logic        w_word_ok;

    // A redirect arriving on the slot-end cycle itself is honoured at that edge.
    assign w_slot_end = (r_ctr == 2'd3);
    assign w_pend     = r_pend | i_fe_redir;
    assign w_pend_pc  = i_fe_redir ? i_fe_redir_pc : r_pend_pc;
    assign w_abort    = w_slot_end & (w_pend | i_fe_stall);
    assign w_word_ok  = (r_state == c_DATA) & ~w_abort;

    always_ff @(posedge i_fe_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            r_ctr     <= 2'd0;
            r_state   <= c_IDLE;
            r_addr    <= RST_PC;
            r_pend_pc <= 16'h0000;
            r_pend    <= 1'b0;
            r_pc      <= RST_PC;
            r_vld     <= 1'b0;
            r_enc     <= 4'h0;
        end else begin
            r_ctr <= r_ctr + 2'd1;
            r_enc <= (r_state == c_DATA) ? i_fe_mem_sio : 4'h0;

            if (w_abort) begin
                // r_addr still names the word whose first nibble is being dropped.
                r_state <= c_IDLE;
                if (w_pend) begin
                    r_addr <= w_pend_pc;
                    r_pend <= 1'b0;
                end
            end else begin
                if (i_fe_redir) begin
                    r_pend    <= 1'b1;
                    r_pend_pc <= i_fe_redir_pc;
                end
                case (r_state)
                    c_IDLE:  if (w_slot_end) r_state <= c_CMD;
                    c_CMD:   if (r_ctr == 2'd1) r_state <= c_ADDR;
                    c_ADDR:  if (r_ctr == 2'd1) r_state <= c_DUMMY;
                    c_DUMMY: r_state <= c_DATA;
                    c_DATA:  if (w_slot_end) r_addr <= r_addr + 16'd1;
                    default: r_state <= c_IDLE;
                endcase
            end

            if (w_slot_end) begin
                r_vld <= w_word_ok;
                if (w_word_ok) r_pc <= r_addr;
            end
        end
    end

    always_comb begin
        o_fe_mem_sio = 4'h0;
        o_fe_mem_oe  = 1'b0;
        case (r_state)
            c_CMD: begin
                o_fe_mem_oe  = 1'b1;
                o_fe_mem_sio = (r_ctr == 2'd1) ? 4'h3 : 4'h0;
            end
            c_ADDR: begin
                // ADDR spans ctr 2,3,0,1: address goes out MSB nibble first.
                o_fe_mem_oe = 1'b1;
                case (r_ctr)
                    2'd2:    o_fe_mem_sio = r_addr[15:12];
                    2'd3:    o_fe_mem_sio = r_addr[11:8];
                    2'd0:    o_fe_mem_sio = r_addr[7:4];
                    default: o_fe_mem_sio = r_addr[3:0];
                endcase
            end
            default: begin
                o_fe_mem_sio = 4'h0;
                o_fe_mem_oe  = 1'b0;
            end
        endcase
    end

    assign o_fe_ctr      = r_ctr;
    assign o_fe_enc      = r_enc;
    assign o_fe_enc_vld  = r_vld;
    assign o_fe_pc       = r_pc;
    assign o_fe_mem_cs_n = (r_state == c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_idli_fetch_m.sv
`default_nettype none
// ============================================================================
// Module   : tb_idli_fetch_m
// Purpose  : Self-checking bench for idli_fetch_m with a serial memory model
//            and a scoreboard of expected {pc, word} presentations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_fetch_m;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  o_fe_ctr;
    logic [3:0]  o_fe_enc;
    logic        o_fe_enc_vld;
    logic [15:0] o_fe_pc;
    logic        i_fe_stall;
    logic        i_fe_redir;
    logic [15:0] i_fe_redir_pc;
    logic        o_fe_mem_cs_n;
    logic [3:0]  o_fe_mem_sio;
    logic        o_fe_mem_oe;
    logic [3:0]  mem_sio = 4'h0;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb[$];

    idli_fetch_m #(.RST_PC(16'h0000)) dut (
        .i_fe_gck      (clk),
        .i_ex_rst_n    (rst_n),
        .o_fe_ctr      (o_fe_ctr),
        .o_fe_enc      (o_fe_enc),
        .o_fe_enc_vld  (o_fe_enc_vld),
        .o_fe_pc       (o_fe_pc),
        .i_fe_stall    (i_fe_stall),
        .i_fe_redir    (i_fe_redir),
        .i_fe_redir_pc (i_fe_redir_pc),
        .o_fe_mem_cs_n (o_fe_mem_cs_n),
        .o_fe_mem_sio  (o_fe_mem_sio),
        .o_fe_mem_oe   (o_fe_mem_oe),
        .i_fe_mem_sio  (mem_sio)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memword(input logic [15:0] a);
        if (a == 16'h0000) return 16'hA5C3;
        if (a == 16'h0001) return 16'h1234;
        return {a[7:0], a[15:8]} ^ 16'h3C96;
    endfunction

    // Serial memory: decodes command/address, then streams words low nibble first.
    int          mk = -1;
    logic [15:0] maddr = 16'h0000;
    logic [15:0] last_addr = 16'hxxxx;
    always @(negedge clk) begin
        logic [15:0] w;
        int idx;
        if (o_fe_mem_cs_n !== 1'b0) begin
            mk      = -1;
            mem_sio = 4'h0;
        end else begin
            mk = mk + 1;
            mem_sio = 4'h0;
            if (mk == 0 || mk == 1) begin
                total++;
                if (o_fe_mem_sio !== ((mk == 0) ? 4'h0 : 4'h3) || o_fe_mem_oe !== 1'b1) begin
                    bad++;
                    $display("FAIL mem_cmd k=%0d got sio=%h oe=%b required sio=%h oe=1",
                             mk, o_fe_mem_sio, o_fe_mem_oe, (mk == 0) ? 4'h0 : 4'h3);
                end
            end else if (mk <= 5) begin
                maddr[(5 - mk) * 4 +: 4] = o_fe_mem_sio;
                if (mk == 5) last_addr = maddr;
            end else if (mk >= 7) begin
                idx     = mk - 7;
                w       = memword(maddr + 16'(idx / 4));
                mem_sio = w[(idx % 4) * 4 +: 4];
            end
        end
    end

    // Slot monitor: pops the scoreboard for every valid slot it sees.
    logic        m_active = 1'b0;
    logic        m_vld;
    logic [15:0] m_pc;
    logic [15:0] m_word;
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_n !== 1'b1) begin
            m_active = 1'b0;
        end else begin
            if (o_fe_ctr == 2'd0) begin
                m_active = 1'b1;
                m_vld    = o_fe_enc_vld;
                m_pc     = o_fe_pc;
                m_word   = 16'h0000;
            end else if (m_active) begin
                total++;
                if (o_fe_enc_vld !== m_vld || o_fe_pc !== m_pc) begin
                    bad++;
                    $display("FAIL slot_stable ctr=%0d got vld=%b pc=%h required vld=%b pc=%h",
                             o_fe_ctr, o_fe_enc_vld, o_fe_pc, m_vld, m_pc);
                end
            end
            if (m_active) m_word[int'(o_fe_ctr) * 4 +: 4] = o_fe_enc;
            if (m_active && o_fe_ctr == 2'd3 && m_vld === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected got pc=%h word=%h required none", m_pc, m_word);
                end else begin
                    e = sb.pop_front();
                    if ({m_pc, m_word} !== e) begin
                        bad++;
                        $display("FAIL sb_word got pc=%h word=%h required pc=%h word=%h",
                                 m_pc, m_word, e[31:16], e[15:0]);
                    end
                end
            end
        end
    end

    task automatic edge3(input logic s);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_fe_ctr !== 2'd3 && n < 8);
        if (o_fe_ctr !== 2'd3) begin
            total++;
            bad++;
            $display("FAIL ctr_timeout got ctr=%0d required 3", o_fe_ctr);
        end
        i_fe_stall = s;
        @(posedge clk);
    endtask

    task automatic preset_pc(input logic [15:0] a);
        @(negedge clk);
        i_fe_redir    = 1'b1;
        i_fe_redir_pc = a;
        @(negedge clk);
        i_fe_redir    = 1'b0;
        edge3(1'b1);
    endtask

    // Entered at the negedge where reset was released (cycle 0), stall low.
    task automatic run_from_reset();
        logic [15:0] w0 = 16'hA5C3;
        logic [15:0] w1 = 16'h1234;
        logic [3:0]  en;
        sb.push_back({16'h0000, memword(16'h0000)});
        sb.push_back({16'h0001, memword(16'h0001)});
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            total++;
            if (c <= 3 && o_fe_mem_cs_n !== 1'b1) begin
                bad++; $display("FAIL boot_idle c=%0d got cs_n=%b required 1", c, o_fe_mem_cs_n);
            end else if ((c == 4 || c == 5) &&
                         (o_fe_mem_cs_n !== 1'b0 || o_fe_mem_oe !== 1'b1 ||
                          o_fe_mem_sio !== ((c == 4) ? 4'h0 : 4'h3))) begin
                bad++; $display("FAIL boot_cmd c=%0d got cs_n=%b oe=%b sio=%h", c, o_fe_mem_cs_n, o_fe_mem_oe, o_fe_mem_sio);
            end else if (c >= 6 && c <= 9 && (o_fe_mem_oe !== 1'b1 || o_fe_mem_sio !== 4'h0)) begin
                bad++; $display("FAIL boot_addr c=%0d got oe=%b sio=%h required oe=1 sio=0", c, o_fe_mem_oe, o_fe_mem_sio);
            end else if (c == 10 && (o_fe_mem_oe !== 1'b0 || o_fe_mem_sio !== 4'h0 || o_fe_mem_cs_n !== 1'b0)) begin
                bad++; $display("FAIL boot_dummy got oe=%b sio=%h cs_n=%b required 0 0 0", o_fe_mem_oe, o_fe_mem_sio, o_fe_mem_cs_n);
            end else if (c == 11 && o_fe_enc_vld !== 1'b0) begin
                bad++; $display("FAIL boot_novld got vld=%b required 0", o_fe_enc_vld);
            end else if (c >= 12) begin
                en = (c < 16) ? w0[(c - 12) * 4 +: 4] : w1[(c - 16) * 4 +: 4];
                if (o_fe_enc_vld !== 1'b1 || o_fe_enc !== en ||
                    o_fe_pc !== ((c < 16) ? 16'h0000 : 16'h0001)) begin
                    bad++;
                    $display("FAIL boot_data c=%0d got vld=%b enc=%h pc=%h required vld=1 enc=%h pc=%h",
                             c, o_fe_enc_vld, o_fe_enc, o_fe_pc, en, (c < 16) ? 16'h0000 : 16'h0001);
                end
            end
            if (c == 19) i_fe_stall = 1'b1;
        end
        edge3(1'b1);
        edge3(1'b1);
        edge3(1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_fe_stall = 1'b0;
        i_fe_redir = 1'b0;
        i_fe_redir_pc = 16'h0000;
        repeat (3) @(negedge clk);
        total++;
        if (o_fe_ctr !== 2'd0 || o_fe_mem_cs_n !== 1'b1 || o_fe_mem_oe !== 1'b0 || o_fe_mem_sio !== 4'h0 ||
            o_fe_enc !== 4'h0 || o_fe_enc_vld !== 1'b0 || o_fe_pc !== 16'h0000) begin
            bad++;
            $display("FAIL reset_state got ctr=%0d cs_n=%b oe=%b sio=%h enc=%h vld=%b pc=%h required 0 1 0 0 0 0 0000",
                     o_fe_ctr, o_fe_mem_cs_n, o_fe_mem_oe, o_fe_mem_sio, o_fe_enc, o_fe_enc_vld, o_fe_pc);
        end
        rst_n = 1'b1;
        run_from_reset();
    endtask

    task automatic test_redirect();
        sb.push_back({16'h0002, memword(16'h0002)});
        sb.push_back({16'h0100, memword(16'h0100)});
        sb.push_back({16'h0101, memword(16'h0101)});
        edge3(1'b0); edge3(1'b0); edge3(1'b0);
        @(negedge clk);
        @(negedge clk);
        i_fe_redir = 1'b1; i_fe_redir_pc = 16'h0100;
        @(negedge clk);
        i_fe_redir = 1'b0;
        edge3(1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (o_fe_mem_cs_n !== 1'b1 || o_fe_enc_vld !== 1'b0) begin
                bad++; $display("FAIL redir_idle i=%0d got cs_n=%b vld=%b required 1 0", i, o_fe_mem_cs_n, o_fe_enc_vld);
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0 || i == 7) begin
                total++;
                if ((i == 0 && o_fe_mem_cs_n !== 1'b0) || (i == 7 && o_fe_enc_vld !== 1'b0)) begin
                    bad++; $display("FAIL redir_restart i=%0d got cs_n=%b vld=%b", i, o_fe_mem_cs_n, o_fe_enc_vld);
                end
            end
        end
        @(negedge clk);
        total++;
        if (o_fe_enc_vld !== 1'b1 || o_fe_pc !== 16'h0100) begin
            bad++; $display("FAIL redir_first got vld=%b pc=%h required 1 0100", o_fe_enc_vld, o_fe_pc);
        end
        edge3(1'b0);
        edge3(1'b1); edge3(1'b1); edge3(1'b1);
        total++;
        if (last_addr !== 16'h0100) begin
            bad++; $display("FAIL redir_addr got %h required 0100", last_addr);
        end
    endtask

    task automatic test_stall();
        preset_pc(16'h0003);
        for (int a = 3; a <= 7; a++) sb.push_back({16'(a), memword(16'(a))});
        repeat (5) edge3(1'b0);
        for (int i = 0; i < 3; i++) begin
            edge3(1'b1);
            @(negedge clk);
            total++;
            if (o_fe_enc_vld !== 1'b0 || o_fe_pc !== 16'h0005) begin
                bad++; $display("FAIL stall_hold i=%0d got vld=%b pc=%h required 0 0005", i, o_fe_enc_vld, o_fe_pc);
            end
        end
        edge3(1'b0); edge3(1'b0); edge3(1'b0);
        @(negedge clk);
        total++;
        if (o_fe_enc_vld !== 1'b1 || o_fe_pc !== 16'h0006) begin
            bad++; $display("FAIL stall_resume got vld=%b pc=%h required 1 0006", o_fe_enc_vld, o_fe_pc);
        end
        edge3(1'b0);
        edge3(1'b1); edge3(1'b1); edge3(1'b1);
        total++;
        if (last_addr !== 16'h0006) begin
            bad++; $display("FAIL stall_addr got %h required 0006", last_addr);
        end
    endtask

    task automatic test_double_redirect();
        preset_pc(16'h0010);
        sb.push_back({16'h0010, memword(16'h0010)});
        sb.push_back({16'h0300, memword(16'h0300)});
        sb.push_back({16'h0301, memword(16'h0301)});
        edge3(1'b0); edge3(1'b0); edge3(1'b0);
        @(negedge clk);
        i_fe_redir = 1'b1; i_fe_redir_pc = 16'h0200;
        @(negedge clk);
        i_fe_redir_pc = 16'h0300;
        @(negedge clk);
        i_fe_redir = 1'b0;
        edge3(1'b1);
        edge3(1'b1);
        @(negedge clk);
        total++;
        if (o_fe_mem_cs_n !== 1'b1) begin
            bad++; $display("FAIL dbl_stall_idle got cs_n=%b required 1", o_fe_mem_cs_n);
        end
        repeat (4) edge3(1'b0);
        edge3(1'b1); edge3(1'b1); edge3(1'b1);
        total++;
        if (last_addr !== 16'h0300) begin
            bad++; $display("FAIL dbl_addr got %h required 0300", last_addr);
        end
    endtask

    task automatic test_wrap();
        preset_pc(16'hFFFF);
        sb.push_back({16'hFFFF, memword(16'hFFFF)});
        sb.push_back({16'h0000, memword(16'h0000)});
        repeat (4) edge3(1'b0);
        @(negedge clk);
        total++;
        if (o_fe_mem_cs_n !== 1'b0 || o_fe_enc_vld !== 1'b1 || o_fe_pc !== 16'h0000) begin
            bad++; $display("FAIL wrap got cs_n=%b vld=%b pc=%h required 0 1 0000", o_fe_mem_cs_n, o_fe_enc_vld, o_fe_pc);
        end
        edge3(1'b1); edge3(1'b1); edge3(1'b1);
    endtask

    task automatic test_reset_mid();
        edge3(1'b0);
        @(negedge clk);
        @(negedge clk);
        i_fe_redir = 1'b1; i_fe_redir_pc = 16'h0777;
        @(negedge clk);
        i_fe_redir = 1'b0;
        total++;
        if (o_fe_mem_oe !== 1'b1 || o_fe_mem_cs_n !== 1'b0) begin
            bad++; $display("FAIL rstmid_pre got oe=%b cs_n=%b required 1 0", o_fe_mem_oe, o_fe_mem_cs_n);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (o_fe_ctr !== 2'd0 || o_fe_mem_cs_n !== 1'b1 || o_fe_mem_oe !== 1'b0 || o_fe_mem_sio !== 4'h0 ||
            o_fe_enc !== 4'h0 || o_fe_enc_vld !== 1'b0 || o_fe_pc !== 16'h0000) begin
            bad++;
            $display("FAIL rstmid_async got ctr=%0d cs_n=%b oe=%b sio=%h enc=%h vld=%b pc=%h required 0 1 0 0 0 0 0000",
                     o_fe_ctr, o_fe_mem_cs_n, o_fe_mem_oe, o_fe_mem_sio, o_fe_enc, o_fe_enc_vld, o_fe_pc);
        end
        i_fe_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_from_reset();
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_stall();
        test_double_redirect();
        test_wrap();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_leftover got %0d entries required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/idli_fetch_m.md
IDLI_FETCH_M -- requirements
Module: idli_fetch_m

Interface
REQ-001 Parameter: RST_PC, default 16'h0000, word address of the first instruction fetched after reset.
REQ-002 i_fe_gck  input  1  clock, all state updates on its rising edge.
REQ-003 i_ex_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 o_fe_ctr  output  2  free-running sync counter shared with EX; EX samples a complete encoding when o_fe_ctr == 3.
REQ-005 o_fe_enc  output  4  instruction encoding nibble; nibble k of the 16-bit word presented while o_fe_ctr == k, low nibble first.
REQ-006 o_fe_enc_vld  output  1  encoding valid; constant across all 4 cycles of a word slot.
REQ-007 o_fe_pc  output  16  word address of the encoding currently presented.
REQ-008 i_fe_stall  input  1  EX cannot accept further words; sampled only when o_fe_ctr == 3.
REQ-009 i_fe_redir  input  1  single-cycle redirect request, sampled in any cycle.
REQ-010 i_fe_redir_pc  input  16  redirect target word address, valid with i_fe_redir.
REQ-011 o_fe_mem_cs_n  output  1  serial memory chip select, active-low.
REQ-012 o_fe_mem_sio  output  4  command/address nibble to memory.
REQ-013 o_fe_mem_oe  output  1  1 = block drives o_fe_mem_sio; 0 = memory drives i_fe_mem_sio.
REQ-014 i_fe_mem_sio  input  4  read data nibble from memory.

Function
REQ-015 o_fe_ctr SHALL increment by 1 every cycle, wrapping 3 -> 0; it never stalls.
REQ-016 FSM states IDLE, CMD, ADDR, DUMMY, DATA; o_fe_mem_cs_n = 1 only in IDLE.
REQ-017 IDLE -> CMD only at end of a cycle with o_fe_ctr == 3, when no abort is pending and i_fe_stall is low.
REQ-018 CMD: 2 cycles (ctr 0,1), o_fe_mem_sio = 4'h0 then 4'h3 (read 0x03), oe = 1.
REQ-019 ADDR: 4 cycles (ctr 2,3,0,1), fetch address driven MSB nibble first, oe = 1.
REQ-020 DUMMY: 1 cycle (ctr 2), oe = 0, o_fe_mem_sio = 0.
REQ-021 DATA: oe = 0; i_fe_mem_sio registered every cycle; o_fe_enc = registered nibble, so memory nibble at ctr 3,0,1,2 appears at o_fe_enc in ctr 0,1,2,3.
REQ-022 First valid slot starts 8 cycles after CMD entry; o_fe_enc_vld = 1 for each fully received word slot while in DATA, else 0.
REQ-023 Fetch address increments by 1 per word received; o_fe_pc advances by 1 at each slot boundary with a valid word; both wrap 16'hFFFF -> 16'h0000 with no special handling.
REQ-024 Redirect: i_fe_redir latches i_fe_redir_pc into a pending register; a later redirect before action overwrites it.
REQ-025 Abort: at end of any cycle with o_fe_ctr == 3, if redirect pending or i_fe_stall high, FSM -> IDLE from any state; partially received nibble discarded; next slot o_fe_enc_vld = 0.
REQ-026 Restart address after abort = pending redirect target if any (pending cleared on restart), else address of the first unpresented word.
REQ-027 Stall and redirect together: target latched, IDLE held until i_fe_stall low at a ctr == 3 edge.
REQ-028 IDLE lasts at least one full 4-cycle slot (cs_n high >= 4 cycles).
REQ-029 o_fe_pc on abort: unchanged while IDLE; loads restart address when first new valid slot begins.

Reset
REQ-030 While i_ex_rst_n low: o_fe_ctr = 0, state IDLE, o_fe_mem_cs_n = 1, o_fe_mem_oe = 0, o_fe_mem_sio = 0, o_fe_enc = 0, o_fe_enc_vld = 0, o_fe_pc = RST_PC, fetch address = RST_PC, redirect pending cleared.
REQ-031 Reset assertion mid-transaction SHALL take effect immediately (asynchronously), discarding all in-flight data.

Verification
REQ-032 Reset release (cycle 0), RST_PC = 0, memory returns 16'hA5C3 then 16'h1234 -> CMD cycles 4-5, address 0000 cycles 6-9, o_fe_enc = 3,C,5,A cycles 12-15 with vld = 1, o_fe_pc = 0; next slot pc = 1, nibbles 4,3,2,1.
REQ-033 i_fe_redir pulse with target 16'h0100 at ctr 1 during DATA -> cs_n high from next ctr 0 for 4 cycles, vld = 0 for that slot, address 0100 driven in ADDR, first valid word o_fe_pc = 0x0100 13 cycles after abort edge.
REQ-034 i_fe_stall high at ctr 3 for 3 slots while presenting pc = 5 -> vld = 0 for those slots, restart fetches address 6, o_fe_pc = 6 on first valid slot.
REQ-035 Two redirects (0x0200 then 0x0300) within one slot, plus stall held 2 slots -> only 0x0300 fetched, after stall drops.
REQ-036 Fetch starting at 16'hFFFF streaming 2 words -> o_fe_pc 0xFFFF then 0x0000, no cs_n deassertion.
REQ-037 i_ex_rst_n pulsed low during ADDR -> all outputs at reset values immediately, fetch restarts from RST_PC per REQ-032 timing.
